// File: rtl/serial_pkg.sv
// serial_pkg: receiver state encoding, parity mode constants and the parity check helper
package serial_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic logic parity_error(input logic data_xor, input logic par_bit, input int mode);
    return (mode == PAR_NONE) ? 1'b0 : ((data_xor ^ par_bit) != (mode == PAR_ODD));
  endfunction
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: sample strobe generator, ticks after half a bit (i_mid) or a full bit since load/last tick
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  input  logic i_mid,
  output logic o_tick
);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  logic [TW-1:0] r_cnt;
  assign o_tick = (CLKS_PER_BIT == 1) || (r_cnt == (i_mid ? HALF : FULL));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else r_cnt <= (i_load || o_tick) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/serial_rx_param.sv
// serial_rx_param: parameterised UART-style receiver with a one-entry output register and overrun flag
module serial_rx_param
  import serial_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_D = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
  state_t            r_state, w_next;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift, r_data;
  logic              r_perr, r_ferr, r_valid, r_operr, r_oferr, r_overrun;
  logic              w_tick, w_load, w_done;
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk), .rstn(rstn), .i_load(w_load), .i_mid(r_state == S_START), .o_tick(w_tick)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // With one clock per bit the start edge itself is the start sample, so START is bypassed.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = 1'b1;
        if (!serial_in) w_next = (CLKS_PER_BIT == 1) ? S_DATA : S_START;
      end
      S_START:  if (w_tick) w_next = serial_in ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && r_bit == LAST_D) w_next = (PARITY_MODE == PAR_NONE) ? S_STOP : S_PARITY;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick && r_bit == LAST_S) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  assign w_done = (r_state == S_STOP) && w_tick && (r_bit == LAST_S);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit     <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_operr   <= 1'b0;
      r_oferr   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_bit  <= '0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (r_state == S_DATA && w_tick) begin
        r_shift <= {serial_in, r_shift[DATA_W-1:1]};
        r_bit   <= (r_bit == LAST_D) ? '0 : r_bit + 1'b1;
      end
      if (r_state == S_PARITY && w_tick) r_perr <= parity_error(^r_shift, serial_in, PARITY_MODE);
      if (r_state == S_STOP && w_tick) begin
        r_ferr <= r_ferr | ~serial_in;
        r_bit  <= w_done ? '0 : r_bit + 1'b1;
      end
      // A completing frame only lands if the held word is empty or being consumed this cycle.
      if (w_done && (!r_valid || out_ready)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_operr <= r_perr;
        r_oferr <= r_ferr | ~serial_in;
      end else if (out_ready) r_valid <= 1'b0;
      r_overrun <= w_done && r_valid && !out_ready;
    end
  end
  assign out_valid  = r_valid;
  assign data_out   = r_data;
  assign parity_err = r_operr;
  assign frame_err  = r_oferr;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_serial_rx_param.sv
// tb_serial_rx_param: scoreboard bench driving three receiver configurations with directed and random frames
module tb_serial_rx_param;
  typedef struct packed {logic [15:0] d; logic pe; logic fe;} exp_t;
  localparam int NB[3]   = '{7, 7, 8};
  localparam int MODE[3] = '{1, 2, 0};
  localparam int NS[3]   = '{1, 1, 2};
  localparam int CPB[3]  = '{1, 3, 16};
  logic clk = 1'b0, rstn = 1'b0;
  logic sin[3], rdy[3], v[3], pe[3], fe[3], ov[3];
  logic [15:0] dd[3];
  logic [6:0] d0, d1;
  logic [7:0] d2;
  exp_t q[3][$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int got[3] = '{0, 0, 0}, exp_got[3] = '{0, 0, 0}, ov_cnt[3] = '{0, 0, 0}, ov_exp[3] = '{0, 0, 0};
  always #5 clk = ~clk;
  serial_rx_param u0 (.clk(clk), .rstn(rstn), .serial_in(sin[0]), .out_ready(rdy[0]), .out_valid(v[0]),
                      .data_out(d0), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
  serial_rx_param #(.DATA_W(7), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(3)) u1 (
    .clk(clk), .rstn(rstn), .serial_in(sin[1]), .out_ready(rdy[1]), .out_valid(v[1]),
    .data_out(d1), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
  serial_rx_param #(.DATA_W(8), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(16)) u2 (
    .clk(clk), .rstn(rstn), .serial_in(sin[2]), .out_ready(rdy[2]), .out_valid(v[2]),
    .data_out(d2), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));
  assign dd[0] = {9'd0, d0};
  assign dd[1] = {9'd0, d1};
  assign dd[2] = {8'd0, d2};
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) ov_cnt[i]++;
        if (v[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_word inst%0d: got data=%h with no word expected", i, dd[i]);
          end else begin
            mon_e = q[i][0];
            if ({dd[i], pe[i], fe[i]} !== {mon_e.d, mon_e.pe, mon_e.fe}) begin
              errors++;
              $display("FAIL word inst%0d: got data=%h pe=%b fe=%b, expected data=%h pe=%b fe=%b",
                       i, dd[i], pe[i], fe[i], mon_e.d, mon_e.pe, mon_e.fe);
            end
            if (rdy[i]) begin
              void'(q[i].pop_front());
              got[i]++;
            end
          end
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic rst_chk();
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", int'(v[i]), 0);
      chk("reset_data", int'(dd[i]), 0);
      chk("reset_flags", int'({pe[i], fe[i], ov[i]}), 0);
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 3000) begin
      idle(1);
      n++;
    end
    chk("drain_outstanding", q[0].size() + q[1].size() + q[2].size(), 0);
  endtask
  // pbs: fixed parity bit value, or -1 for a random one; push=0 means the frame is expected to be dropped
  task automatic frame(input int i, input logic [15:0] data, input int pbs, input logic [1:0] stops,
                       input bit push, input bit last_rdy);
    logic bits[$];
    exp_t ex;
    logic pb;
    int ones;
    ex.d = data & ((16'd1 << NB[i]) - 16'd1);
    pb = (pbs < 0) ? 1'($urandom_range(0, 1)) : 1'(pbs);
    ones = $countones(ex.d) + ((MODE[i] != 0 && pb) ? 1 : 0);
    ex.pe = (MODE[i] == 1) ? (ones % 2 == 1) : (MODE[i] == 2) ? (ones % 2 == 0) : 1'b0;
    ex.fe = !stops[0] || (NS[i] == 2 && !stops[1]);
    if (push) begin
      q[i].push_back(ex);
      exp_got[i]++;
    end else ov_exp[i]++;
    bits.push_back(1'b0);
    for (int k = 0; k < NB[i]; k++) bits.push_back(ex.d[k]);
    if (MODE[i] != 0) bits.push_back(pb);
    for (int k = 0; k < NS[i]; k++) bits.push_back(stops[k]);
    foreach (bits[k]) begin
      if (last_rdy && k == bits.size() - 1) rdy[i] = 1'b1;
      sin[i] = bits[k];
      idle(CPB[i]);
    end
    sin[i] = 1'b1;
  endtask
  initial begin
    int gap;
    logic [1:0] st;
    for (int i = 0; i < 3; i++) begin
      sin[i] = 1'b1;
      rdy[i] = 1'b1;
    end
    idle(3);
    rst_chk();
    rstn = 1'b1;
    idle(2);
    frame(0, 16'h55, 0, 2'b11, 1, 0);
    idle(3);
    frame(0, 16'h55, 1, 2'b11, 1, 0);
    frame(1, 16'h55, 1, 2'b11, 1, 0);
    frame(2, 16'hA3, -1, 2'b01, 1, 0);
    idle(40);
    sin[2] = 1'b0;
    idle(5);
    sin[2] = 1'b1;
    idle(40);
    drain();
    rdy[0] = 1'b0;
    frame(0, 16'h11, -1, 2'b11, 1, 0);
    frame(0, 16'h22, -1, 2'b11, 0, 0);
    idle(5);
    rdy[0] = 1'b1;
    drain();
    chk("overrun_on_drop", ov_cnt[0], ov_exp[0]);
    rdy[0] = 1'b0;
    frame(0, 16'h11, -1, 2'b11, 1, 0);
    frame(0, 16'h22, -1, 2'b11, 1, 1);
    drain();
    chk("no_overrun_on_accept", ov_cnt[0], ov_exp[0]);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < ((i == 2) ? 6 : 30); k++) begin
        gap = $urandom_range(0, 4);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        for (int g = 0; g < gap; g++) begin
          rdy[i] = 1'($urandom);
          idle(1);
        end
        rdy[i] = 1'b1;
        frame(i, 16'($urandom), -1, st, 1, 0);
        if (st != 2'b11) idle(2 * CPB[i]);
      end
      drain();
    end
    rdy[0] = 1'b0;
    frame(0, 16'h2A, -1, 2'b11, 1, 0);
    sin[0] = 1'b0;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      sin[0] = 1'($urandom);
      idle(1);
    end
    rstn = 1'b0;
    #1;
    rst_chk();
    for (int i = 0; i < 3; i++) begin
      exp_got[i] -= q[i].size();
      q[i].delete();
    end
    sin[0] = 1'b1;
    idle(3);
    rst_chk();
    rstn = 1'b1;
    rdy[0] = 1'b1;
    idle(3);
    frame(0, 16'h7F, 1, 2'b11, 1, 0);
    idle(5);
    drain();
    for (int i = 0; i < 3; i++) begin
      chk("words_delivered", got[i], exp_got[i]);
      chk("overrun_total", ov_cnt[i], ov_exp[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_rx_param.md
SERIAL_RX_PARAM -- requirements
Module: serial_rx_param

Interface
REQ-001 Parameter DATA_W, default 7: data bits per frame, legal 5..16.
REQ-002 Parameter PARITY_MODE, default 1: 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame, legal 1..2.
REQ-004 Parameter CLKS_PER_BIT, default 1: clk cycles per serial bit, legal 1..4095.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 serial_in  input  1  line input; idle high, start bit low.
REQ-008 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-009 out_valid  output  1  data_out holds an unconsumed word.
REQ-010 data_out  output  DATA_W  received word; first bit received lands in bit 0.
REQ-011 parity_err  output  1  parity check failed for the held word; 0 when PARITY_MODE = 0.
REQ-012 frame_err  output  1  a stop bit sampled low for the held word.
REQ-013 overrun  output  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE = 0.
REQ-015 IDLE: serial_in sampled low -> START, bit-timer loaded.
REQ-016 CLKS_PER_BIT = 1: START lasts zero cycles; first data bit sampled on the next edge, one bit per edge after that.
REQ-017 CLKS_PER_BIT > 1: START re-samples the line after CLKS_PER_BIT/2 cycles; high -> IDLE (glitch, no output); low -> DATA, every later bit sampled CLKS_PER_BIT cycles after the previous sample.
REQ-018 DATA SHALL capture exactly DATA_W bits LSB-first, then go to PARITY or STOP.
REQ-019 Parity: even mode expects XOR(data, parity bit) = 0; odd mode expects 1; a mismatch sets the frame's parity error.
REQ-020 STOP SHALL sample STOP_BITS bits; any low sample sets the frame's frame error; no early abort.
REQ-021 After the last stop sample, FSM -> IDLE; a low line on the next edge starts a new frame (back-to-back frames supported).
REQ-022 Completion: data, parity error and frame error SHALL be written to the output register together; out_valid rises on the edge after the last stop sample.
REQ-023 Output register holds one entry; outputs stay stable while out_valid = 1 and out_ready = 0.
REQ-024 out_valid and out_ready both high -> out_valid cleared next edge unless a new frame completes that same edge.
REQ-025 Completion with out_valid = 1 and out_ready = 1 in the same cycle: the new word is loaded and out_valid stays 1.
REQ-026 Completion with out_valid = 1 and out_ready = 0: the new frame is discarded, the held word is kept, and overrun pulses for one cycle.
REQ-027 Frames with parity or framing errors SHALL still be delivered, with their flags set.
REQ-028 The bit-timer SHALL be ceil(log2(CLKS_PER_BIT + 1)) bits wide and the bit-counter ceil(log2(DATA_W + 1)) bits wide; no wrap inside a frame.

Reset
REQ-029 rstn low SHALL immediately force: FSM = IDLE, counters = 0, shift register = 0, out_valid = 0, data_out = 0, parity_err = 0, frame_err = 0, overrun = 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; after rstn rises, reception resumes only at the next high-to-low start edge sampled in IDLE.

Structure
REQ-031 Package serial_pkg SHALL hold the state enum, parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), and a parity-function helper.
REQ-032 A single sub-module, serial_bit_timer (load, tick on mid-bit or full-bit count), SHALL generate the sample strobes; everything else lives in serial_rx_param.

Verification
REQ-033 Defaults, start 0, data 0x55 LSB-first, parity 0, stop 1 -> out_valid = 1 with data_out = 0x55, parity_err = 0, frame_err = 0.
REQ-034 Defaults, data 0x55 sent with parity bit 1 -> data_out = 0x55, parity_err = 1; PARITY_MODE = 2 with the same frame -> parity_err = 0.
REQ-035 DATA_W = 8, STOP_BITS = 2, CLKS_PER_BIT = 16, data 0xA3, second stop bit low -> data_out = 0xA3, frame_err = 1; a 5-cycle low glitch in IDLE -> no out_valid.
REQ-036 out_ready held 0, two back-to-back frames 0x11 then 0x22 -> data_out stays 0x11 and overrun pulses once; out_ready = 1 on the second completion cycle -> data_out = 0x22 and no overrun.
REQ-037 rstn asserted after 3 data bits, released, then frame 0x7F sent -> all outputs 0 during reset, then exactly one word 0x7F with no errors.
